// File: rtl/bcd_contador_ud_pkg.sv
// Shared BCD definitions for the counters library.
package bcd_contador_ud_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit,
                                                   input logic [BCD_W-1:0] limit);
        return (digit > limit) ? limit : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_ud.sv
// One BCD decade counting 0..LIMIT in either direction, with load and registered end flags.
module bcd_digit_ud
    import bcd_contador_ud_pkg::*;
#(
    parameter logic [BCD_W-1:0] LIMIT = BCD_MAX
) (
    input  logic             ck,
    input  logic             rst_s,
    input  logic             step_en,
    input  logic             up,
    input  logic             ld,
    input  logic [BCD_W-1:0] d_digit,
    output logic [BCD_W-1:0] q_digit,
    output logic             at_limit,
    output logic             at_zero
);

    logic [BCD_W-1:0] q_d;

    always_comb begin
        q_d = q_digit;
        if (ld) begin
            q_d = bcd_clamp(d_digit, LIMIT);
        end else if (step_en) begin
            if (up) begin
                q_d = (q_digit == LIMIT) ? '0 : q_digit + 4'd1;
            end else begin
                q_d = (q_digit == '0) ? LIMIT : q_digit - 4'd1;
            end
        end
    end

    // Flags are registered from the next value so they line up with q_digit.
    always_ff @(negedge ck) begin
        if (rst_s) begin
            q_digit  <= '0;
            at_limit <= 1'b0;
            at_zero  <= 1'b1;
        end else begin
            q_digit  <= q_d;
            at_limit <= (q_d == LIMIT);
            at_zero  <= (q_d == '0);
        end
    end

endmodule

// File: rtl/bcd_contador_ud.sv
// Multi-digit BCD up/down counter with programmable MS-digit top, load, end flags and wrap pulse.
module bcd_contador_ud
    import bcd_contador_ud_pkg::*;
#(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned TOP_MAX = 5
) (
    input  logic                    ck,
    input  logic                    rst_s,
    input  logic                    enb,
    input  logic                    up,
    input  logic                    ld,
    input  logic [BCD_W*DIGITS-1:0] d,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                    cnt_max,
    output logic                    cnt_min,
    output logic                    wrap
);

    logic [DIGITS-1:0] at_limit;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS-1:0] step_en;

    // Ripple carry/borrow: a digit steps only when every lower digit sits at its end.
    always_comb begin
        logic chain;
        chain   = enb;
        step_en = '0;
        for (int i = 0; i < DIGITS; i++) begin
            step_en[i] = chain;
            chain      = chain & (up ? at_limit[i] : at_zero[i]);
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam logic [BCD_W-1:0] Lim = (i == DIGITS - 1) ? BCD_W'(TOP_MAX) : BCD_MAX;

        bcd_digit_ud #(
            .LIMIT(Lim)
        ) u_digit (
            .ck      (ck),
            .rst_s   (rst_s),
            .step_en (step_en[i]),
            .up      (up),
            .ld      (ld),
            .d_digit (d[BCD_W*i +: BCD_W]),
            .q_digit (q[BCD_W*i +: BCD_W]),
            .at_limit(at_limit[i]),
            .at_zero (at_zero[i])
        );
    end

    assign cnt_max = &at_limit;
    assign cnt_min = &at_zero;

    always_ff @(negedge ck) begin
        if (rst_s) begin
            wrap <= 1'b0;
        end else begin
            wrap <= ~ld & enb & (up ? cnt_max : cnt_min);
        end
    end

endmodule

// File: tb/tb_bcd_contador_ud.sv
// Self-checking bench: directed plan steps plus random traffic against an integer reference model.
module tb_bcd_contador_ud;

    logic        ck;
    logic        rst_a, enb_a, up_a, ld_a;
    logic [7:0]  d_a, q_a;
    logic        max_a, min_a, wrap_a;
    logic        rst_b, enb_b, up_b, ld_b;
    logic [15:0] d_b, q_b;
    logic        max_b, min_b, wrap_b;

    int n_cmp = 0;
    int n_bad = 0;
    int mv[2];
    bit mw[2];
    int nwrap;

    bcd_contador_ud #(.DIGITS(2), .TOP_MAX(5)) dut_a (
        .ck(ck), .rst_s(rst_a), .enb(enb_a), .up(up_a), .ld(ld_a), .d(d_a),
        .q(q_a), .cnt_max(max_a), .cnt_min(min_a), .wrap(wrap_a)
    );

    bcd_contador_ud #(.DIGITS(4), .TOP_MAX(9)) dut_b (
        .ck(ck), .rst_s(rst_b), .enb(enb_b), .up(up_b), .ld(ld_b), .d(d_b),
        .q(q_b), .cnt_max(max_b), .cnt_min(min_b), .wrap(wrap_b)
    );

    initial ck = 1'b1;
    always #5 ck = ~ck;

    function automatic int nd(input int s);
        return (s != 0) ? 4 : 2;
    endfunction

    function automatic int topv(input int s);
        return (s != 0) ? 9 : 5;
    endfunction

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int maxv(input int s);
        return topv(s) * pow10(nd(s) - 1) + pow10(nd(s) - 1) - 1;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_val(input int s, input logic [15:0] dv);
        int v = 0;
        for (int i = nd(s) - 1; i >= 0; i--) begin
            int dig;
            int lim;
            dig = int'(dv[4*i +: 4]);
            lim = (i == nd(s) - 1) ? topv(s) : 9;
            if (dig > lim) dig = lim;
            v = v * 10 + dig;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input int s, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, s, obs, exp);
        end
    endtask

    // One falling edge on instance s; the other instance is held idle.
    task automatic cyc(input int s, input bit r, input bit l, input bit e, input bit u,
                       input logic [15:0] dv);
        logic [15:0] oq;
        logic        omax, omin, owrap;
        @(posedge ck);
        #1;
        if (s == 0) begin
            rst_a = r; ld_a = l; enb_a = e; up_a = u; d_a = dv[7:0];
            rst_b = 1'b0; ld_b = 1'b0; enb_b = 1'b0;
        end else begin
            rst_b = r; ld_b = l; enb_b = e; up_b = u; d_b = dv;
            rst_a = 1'b0; ld_a = 1'b0; enb_a = 1'b0;
        end
        if (r) begin
            mv[s] = 0; mw[s] = 1'b0;
        end else if (l) begin
            mv[s] = load_val(s, dv); mw[s] = 1'b0;
        end else if (e) begin
            if (u) begin
                mw[s] = (mv[s] == maxv(s));
                mv[s] = mw[s] ? 0 : mv[s] + 1;
            end else begin
                mw[s] = (mv[s] == 0);
                mv[s] = mw[s] ? maxv(s) : mv[s] - 1;
            end
        end else begin
            mw[s] = 1'b0;
        end
        @(negedge ck);
        #1;
        oq    = (s != 0) ? q_b : {8'h00, q_a};
        omax  = (s != 0) ? max_b : max_a;
        omin  = (s != 0) ? min_b : min_a;
        owrap = (s != 0) ? wrap_b : wrap_a;
        chk("q", s, 32'(oq), 32'(to_bcd(mv[s])));
        chk("cnt_max", s, 32'(omax), 32'(mv[s] == maxv(s)));
        chk("cnt_min", s, 32'(omin), 32'(mv[s] == 0));
        chk("wrap", s, 32'(owrap), 32'(mw[s]));
    endtask

    initial begin
        rst_a = 1'b0; enb_a = 1'b0; up_a = 1'b0; ld_a = 1'b0; d_a = '0;
        rst_b = 1'b0; enb_b = 1'b0; up_b = 1'b0; ld_b = 1'b0; d_b = '0;

        // Reset and hold
        cyc(0, 1, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 0, 16'h0);
        chk("t1_q", 0, 32'(q_a), 32'h00);
        chk("t1_min", 0, 32'(min_a), 32'h1);
        cyc(1, 1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 16'h0);
        chk("t1_hold", 0, 32'(q_a), 32'h00);

        // Up count through carries
        for (int i = 1; i <= 60; i++) begin
            cyc(0, 0, 0, 1, 1, 16'h0);
            if (i == 9)  chk("t2_q9", 0, 32'(q_a), 32'h09);
            if (i == 10) chk("t2_q10", 0, 32'(q_a), 32'h10);
            if (i == 59) begin
                chk("t2_q59", 0, 32'(q_a), 32'h59);
                chk("t2_max", 0, 32'(max_a), 32'h1);
            end
            if (i == 60) begin
                chk("t2_q60", 0, 32'(q_a), 32'h00);
                chk("t2_wrap", 0, 32'(wrap_a), 32'h1);
            end
        end
        cyc(0, 0, 0, 0, 0, 16'h0);
        chk("t2_wrap_once", 0, 32'(wrap_a), 32'h0);

        // Down count and borrow
        cyc(0, 0, 1, 0, 0, 16'h10);
        cyc(0, 0, 0, 1, 0, 16'h0);
        chk("t3_borrow", 0, 32'(q_a), 32'h09);
        cyc(0, 0, 1, 0, 0, 16'h00);
        cyc(0, 0, 0, 1, 0, 16'h0);
        chk("t3_under", 0, 32'(q_a), 32'h59);
        chk("t3_wrap", 0, 32'(wrap_a), 32'h1);

        // Load clamping and priority
        cyc(0, 0, 1, 1, 1, 16'h7C);
        chk("t4_clamp", 0, 32'(q_a), 32'h59);
        chk("t4_nowrap", 0, 32'(wrap_a), 32'h0);
        cyc(0, 1, 1, 1, 1, 16'h33);
        chk("t4_rst_prio", 0, 32'(q_a), 32'h00);

        // Direction change
        cyc(0, 0, 1, 0, 0, 16'h58);
        cyc(0, 0, 0, 1, 1, 16'h0);
        chk("t5_up", 0, 32'(q_a), 32'h59);
        cyc(0, 0, 0, 1, 0, 16'h0);
        cyc(0, 0, 0, 1, 0, 16'h0);
        chk("t5_down", 0, 32'(q_a), 32'h57);

        // Full-decade config
        cyc(1, 0, 1, 0, 0, 16'h9999);
        cyc(1, 0, 0, 1, 1, 16'h0);
        chk("t6_q", 1, 32'(q_b), 32'h0000);
        chk("t6_wrap", 1, 32'(wrap_b), 32'h1);
        nwrap = 0;
        for (int i = 0; i < 10000; i++) begin
            cyc(1, 0, 0, 1, 1, 16'h0);
            if (wrap_b) nwrap++;
        end
        chk("t6_wraps", 1, 32'(nwrap), 32'd1);
        chk("t6_end", 1, 32'(q_b), 32'h0000);

        // Random traffic on both instances
        for (int i = 0; i < 1600; i++) begin
            int s;
            s = int'($urandom_range(1, 0));
            cyc(s, ($urandom_range(31, 0) == 0), ($urandom_range(7, 0) == 0),
                ($urandom_range(3, 0) != 0), 1'($urandom), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_contador_ud.md
Name: bcd_contador_ud

Overview:
Parametrised multi-digit BCD up/down counter. It is the successor of the single-decade counter in the counters library. Each digit is one decade, chained by internal ripple carry/borrow, and the most significant digit has a programmable top value, so one instance can be a 00-59 timer or a 0000-9999 event counter. It adds count direction, parallel load, a minimum flag and a registered wrap pulse for cascading further stages.

Parameters:
DIGITS, 2, number of BCD digits (1..8); q width = 4*DIGITS
TOP_MAX, 5, highest value of the most significant digit (1..9); lower digits always count 0..9

Ports:
ck  input  1  clock; all state changes on the falling edge of ck
rst_s  input  1  synchronous active-high reset
enb  input  1  count enable; one step per falling edge while high
up  input  1  direction: 1 = increment, 0 = decrement
ld  input  1  parallel load strobe
d  input  4*DIGITS  load value, digit i in bits [4i+3:4i]
q  output  4*DIGITS  count value, BCD, digit 0 least significant
cnt_max  output  1  high while q == MAXV (TOP_MAX followed by 9s)
cnt_min  output  1  high while q == 0
wrap  output  1  one-cycle pulse, registered, on the edge where the count wraps

Behaviour:
- All registers update on the falling edge of ck. No combinational path from inputs to any output.
- Reset: on an edge with rst_s=1: q=0, cnt_max=0, cnt_min=1, wrap=0. All other inputs are ignored.
- Priority per edge: rst_s > ld > enb. With enb=0 and ld=0, q holds and wrap=0.
- Load (ld=1): q <= d, wrap=0; enb is ignored on that edge.
  - Any lower digit >9 loads as 9.
  - An MS digit >TOP_MAX loads as TOP_MAX.
  - Result is always a legal count.
- Up count (enb=1, up=1):
  - Digit 0 increments every edge.
  - Digit i increments only when all lower digits are 9.
  - Lower digit at 9 -> 0. MS digit at TOP_MAX -> 0.
  - q == MAXV -> q becomes 0 and wrap=1 on that edge.
- Down count (enb=1, up=0):
  - Digit 0 decrements every edge.
  - Digit i decrements only when all lower digits are 0.
  - Lower digit at 0 -> 9. MS digit at 0 -> TOP_MAX.
  - q == 0 -> q becomes MAXV and wrap=1.
- Direction may change on any edge; the step uses the value of up sampled at that edge. No extra latency.
- Flags:
  - cnt_max and cnt_min are registered alongside q and always reflect the new q in the same cycle, including after load and reset.
  - wrap is high for exactly one cycle per wrap. Consecutive wraps (possible only when DIGITS=1 and TOP_MAX... n/a) cannot occur. With enb held, wrap repeats every MAXV+1 edges.
- Reset mid-count: the next edge gives q=0 regardless of ld/enb. Counting resumes on the first edge after rst_s falls.
- Latency: 1 edge from enb/ld/rst_s to q and flags.
- No illegal BCD code is ever produced on q.

Decomposition:
- Shared package/header (counters library):
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - function bcd_clamp(digit, limit)
- Sub-module bcd_digit_ud, instantiated DIGITS times via generate.
  - Parameter LIMIT.
  - Inputs: ck, rst_s, step_en, up, ld, d_digit.
  - Outputs: q_digit, at_limit, at_zero.
  - The top level forms each step_en from the AND of enb with the lower digits' at_limit (up) or at_zero (down), and computes the flags and wrap.

Test Plan:
1. Reset and hold: DIGITS=2, TOP_MAX=5; rst_s=1 for 2 edges -> q=0x00, cnt_min=1, cnt_max=0, wrap=0; enb=0 for 5 edges -> q stays 0x00.
2. Up count through carries: from 0x00, enb=1, up=1 for 60 edges.
   - After 9 edges q=0x09; after 10 edges q=0x10.
   - After 59 edges q=0x59 and cnt_max=1.
   - Edge 60: q=0x00, wrap=1 for one cycle, cnt_min=1.
3. Down count and borrow: load 0x10, then up=0 for 1 edge -> q=0x09. Load 0x00, up=0 for 1 edge -> q=0x59, wrap=1, cnt_max=1.
4. Load clamping and priority: ld=1, enb=1, d=0x7C -> q=0x59 (MS clamped to 5, LS clamped to 9), no increment, wrap=0. Then rst_s=1 with ld=1, d=0x33 -> q=0x00.
5. Direction change: q=0x58, up=1 for 1 edge -> q=0x59; up=0 for 2 edges -> q=0x57; no wrap pulse.
6. Full-decade config: DIGITS=4, TOP_MAX=9; load 0x9999, enb=1, up=1 for 1 edge -> q=0x0000, wrap=1. Continue 10000 edges -> exactly one further wrap, q=0x0000 at the end.
